// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full adder built from propagate/generate terms.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  logic p;
  logic g;

  // Propagate/generate form of the full adder.
  always_comb begin
    p  = a ^ b;
    g  = a & b;
    s  = p ^ ci;
    co = g | (p & ci);
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one shared full-adder cell sequenced over
// WIDTH cycles, LSB first, behind valid/ready handshakes on both sides.
// Optional build macro SERIAL_ADDER_SUB_EN adds a 'sub' input (a - b) and
// an 'ovf' signed-overflow output.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
  output logic             ovf,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  state_t state_q, state_d;

  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic [WIDTH-1:0] sum_shift;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             cout_q;
  logic             last_bit;
  logic             fa_s;
  logic             fa_co;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;

`ifdef SERIAL_ADDER_SUB_EN
  logic ovf_q;
`endif

  fa_cell u_fa (
    .a  (a_q[0]),
    .b  (b_q[0]),
    .ci (carry_q),
    .s  (fa_s),
    .co (fa_co)
  );

  // Operand B and carry-in as loaded at accept time.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = sub ? ~b : b;
    carry_load = sub ? 1'b1 : cin;
`else
    b_load     = b;
    carry_load = cin;
`endif
  end

  // Next sum: shift right, new bit enters at the MSB. Written as a shift plus
  // bit insert so WIDTH=1 needs no degenerate slice.
  always_comb begin
    sum_shift            = sum_q >> 1;
    sum_shift[WIDTH-1]   = fa_s;
    last_bit             = (cnt_q == LAST_CNT);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, serial datapath and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b_load;
            carry_q <= carry_load;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          a_q     <= a_q >> 1;
          b_q     <= b_q >> 1;
          carry_q <= fa_co;
          sum_q   <= sum_shift;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (last_bit) begin
            cout_q <= fa_co;
`ifdef SERIAL_ADDER_SUB_EN
            // carry_q here is the carry into the MSB.
            ovf_q  <= carry_q ^ fa_co;
`endif
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
`ifdef SERIAL_ADDER_SUB_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed self-checking bench for serial_adder_ctrl (WIDTH=8 and WIDTH=1).
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] sum;
  logic       cout;
  logic       busy;

  logic       in_valid1;
  logic       in_ready1;
  logic [0:0] a1;
  logic [0:0] b1;
  logic       cin1;
  logic       out_valid1;
  logic       out_ready1;
  logic [0:0] sum1;
  logic       cout1;
  logic       busy1;

`ifdef SERIAL_ADDER_SUB_EN
  logic sub;
  logic ovf;
  logic sub1;
  logic ovf1;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub),
    .ovf       (ovf),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid1),
    .in_ready  (in_ready1),
    .a         (a1),
    .b         (b1),
    .cin       (cin1),
`ifdef SERIAL_ADDER_SUB_EN
    .sub       (sub1),
    .ovf       (ovf1),
`endif
    .out_valid (out_valid1),
    .out_ready (out_ready1),
    .sum       (sum1),
    .cout      (cout1),
    .busy      (busy1)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one operand set to the 8-bit DUT, wait for the result and check it.
  // Leaves the DUT in DONE if out_ready is low on return.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_, input logic tcin,
                        input logic tsub, input logic [7:0] exp_sum,
                        input logic exp_cout, input string tag);
    int n;
    @(negedge clk);
    check({tag, "_in_ready"}, in_ready, 1'b1);
    a        = ta;
    b        = tb_;
    cin      = tcin;
`ifdef SERIAL_ADDER_SUB_EN
    sub      = tsub;
`else
    if (tsub) $display("note: sub requested without SERIAL_ADDER_SUB_EN");
`endif
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    a        = 8'hA5;
    b        = 8'h5A;
    check({tag, "_busy"}, busy, 1'b1);
    n = 0;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, 8);
    check({tag, "_sum"}, sum, exp_sum);
    check({tag, "_cout"}, cout, exp_cout);
  endtask

  initial begin
    reset      = 1'b1;
    in_valid   = 1'b0;
    a          = '0;
    b          = '0;
    cin        = 1'b0;
    out_ready  = 1'b1;
    in_valid1  = 1'b0;
    a1         = '0;
    b1         = '0;
    cin1       = 1'b0;
    out_ready1 = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub        = 1'b0;
    sub1       = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_sum", sum, 8'h00);
    check("rst_cout", cout, 1'b0);
    reset = 1'b0;

    // Basic adds.
    run_op(8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, "add_5a_33");
    run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, "add_ff_01");
    run_op(8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, "add_ff_00_c");
    run_op(8'h80, 8'h80, 1'b1, 1'b0, 8'h01, 1'b1, "add_80_80_c");
    @(negedge clk);
    check("post_hs_out_valid", out_valid, 1'b0);
    check("post_hs_sum_kept", sum, 8'h01);

    // Backpressure with ignored in_valid pulses.
    out_ready = 1'b0;
    run_op(8'h12, 8'h34, 1'b1, 1'b0, 8'h47, 1'b0, "bp");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a        = 8'hEE;
      b        = 8'hEE;
      @(negedge clk);
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_sum", sum, 8'h47);
      check("bp_cout", cout, 1'b0);
      check("bp_in_ready", in_ready, 1'b0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_out_valid", out_valid, 1'b0);
    check("bp_release_in_ready", in_ready, 1'b1);
    check("bp_release_busy", busy, 1'b0);
    run_op(8'h01, 8'h02, 1'b0, 1'b0, 8'h03, 1'b0, "after_bp");

    // Reset during RUN.
    @(negedge clk);
    a        = 8'hF0;
    b        = 8'h0F;
    cin      = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_run_busy", busy, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_sum", sum, 8'h00);
    check("mid_rst_cout", cout, 1'b0);
    run_op(8'h10, 8'h20, 1'b0, 1'b0, 8'h30, 1'b0, "after_rst");

`ifdef SERIAL_ADDER_SUB_EN
    run_op(8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "sub_05_07");
    check("sub_05_07_ovf", ovf, 1'b0);
    run_op(8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, "sub_80_01");
    check("sub_80_01_ovf", ovf, 1'b1);
`endif

    // WIDTH=1 instance: 1+1+1 = 3 -> sum 1, cout 1 after a single RUN cycle.
    begin
      int n;
      @(negedge clk);
      check("w1_in_ready", in_ready1, 1'b1);
      a1        = 1'b1;
      b1        = 1'b1;
      cin1      = 1'b1;
      in_valid1 = 1'b1;
      @(negedge clk);
      in_valid1 = 1'b0;
      check("w1_busy", busy1, 1'b1);
      n = 0;
      while (!out_valid1 && n < 10) begin
        @(negedge clk);
        n++;
      end
      check("w1_latency", n, 1);
      check("w1_sum", sum1, 1'b1);
      check("w1_cout", cout1, 1'b1);
      @(negedge clk);
      check("w1_back_idle", in_ready1, 1'b1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
